// File: rtl/test_data_checker.sv
// test_data_checker: reads the test-data source either every cycle (free-run)
// or on a periodic one-cycle read strobe. It locks onto the incrementing counter
// pattern, then counts received words and mismatches and captures the first mismatch.
module test_data_checker #(
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 16,
  parameter int RD_GAP        = 3
) (
  input  logic                     axi_clk,
  input  logic                     axi_resetn,
  input  logic [31:0]              control,
  input  logic [DATA_WIDTH-1:0]    data,
  output logic                     data_rdStrobe,
  output logic [31:0]              word_count,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic [DATA_WIDTH-1:0]    first_err_data,
  output logic [DATA_WIDTH-1:0]    first_err_expected,
  output logic [3:0]               status
);

  localparam int GAP_W = (RD_GAP > 0) ? $clog2(RD_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(RD_GAP);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_CHECK, S_HALT} state_t;

  state_t                   r_state, w_next;
  logic                     r_mode;
  logic                     r_strobe;
  logic [GAP_W-1:0]         r_gap;
  logic [DATA_WIDTH-1:0]    r_expected;
  logic [31:0]              r_word_count;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;
  logic [DATA_WIDTH-1:0]    r_first_data;
  logic [DATA_WIDTH-1:0]    r_first_exp;
  logic                     r_err_seen;
  logic                     r_locked;

  logic w_en, w_clr, w_mode, w_stop;
  logic w_active, w_mode_chg, w_sample, w_mismatch, w_enter_sync, w_next_active;
  logic w_unused_ctrl;

  // Error counter sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_CNT_WIDTH'(1);
  endfunction

  assign w_en          = control[0];
  assign w_clr         = control[1];
  assign w_mode        = control[2];
  assign w_stop        = control[3];
  assign w_unused_ctrl = ^control[31:4];

  assign w_active      = (r_state == S_SYNC) || (r_state == S_CHECK);
  // A mode flip while running forces a relock; HALT ignores it.
  assign w_mode_chg    = w_active && (w_mode != r_mode);
  // clear and a mode change both discard the coincident sample.
  assign w_sample      = w_en && !w_clr && !w_mode_chg && w_active && (w_mode ? r_strobe : 1'b1);
  assign w_mismatch    = (data != r_expected);
  assign w_enter_sync  = w_en && (w_clr || w_mode_chg || (r_state == S_IDLE));
  assign w_next_active = (w_next == S_SYNC) || (w_next == S_CHECK);

  // Next-state logic: disable beats clear, clear beats everything else.
  always_comb begin
    w_next = r_state;
    if (!w_en) begin
      w_next = S_IDLE;
    end else if (w_clr) begin
      w_next = S_SYNC;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_SYNC;
        S_SYNC:  begin
          if (w_mode_chg)    w_next = S_SYNC;
          else if (w_sample) w_next = S_CHECK;
        end
        S_CHECK: begin
          if (w_mode_chg)                              w_next = S_SYNC;
          else if (w_sample && w_mismatch && w_stop)   w_next = S_HALT;
        end
        S_HALT:  w_next = S_HALT;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // State and last-seen mode registers.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mode  <= w_mode;
    end
  end

  // Read strobe generator: restarts on every (re)entry to SYNC, first pulse one cycle later.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_strobe <= 1'b0;
      r_gap    <= '0;
    end else if (w_enter_sync) begin
      r_strobe <= 1'b0;
      r_gap    <= '0;
    end else if (w_mode && w_next_active) begin
      if (r_gap == '0) begin
        r_strobe <= 1'b1;
        r_gap    <= GAP_MAX;
      end else begin
        r_strobe <= 1'b0;
        r_gap    <= r_gap - GAP_W'(1);
      end
    end else begin
      r_strobe <= 1'b0;
      r_gap    <= '0;
    end
  end

  // Compare datapath: expected tracking, word/error counters, first-error capture.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_expected   <= '0;
      r_word_count <= '0;
      r_err_count  <= '0;
      r_first_data <= '0;
      r_first_exp  <= '0;
      r_err_seen   <= 1'b0;
      r_locked     <= 1'b0;
    end else if (w_clr) begin
      r_expected   <= '0;
      r_word_count <= '0;
      r_err_count  <= '0;
      r_first_data <= '0;
      r_first_exp  <= '0;
      r_err_seen   <= 1'b0;
      r_locked     <= 1'b0;
    end else if (!w_en || w_mode_chg || (r_state == S_IDLE)) begin
      r_locked     <= 1'b0;
    end else if (w_sample) begin
      r_word_count <= r_word_count + 32'd1;
      // Always resync to the received word, so one bad word costs one error.
      r_expected   <= data + DATA_WIDTH'(1);
      if (r_state == S_SYNC) begin
        r_locked <= 1'b1;
      end else if (w_mismatch) begin
        r_err_count <= sat_inc(r_err_count);
        r_err_seen  <= 1'b1;
        if (!r_err_seen) begin
          r_first_data <= data;
          r_first_exp  <= r_expected;
        end
      end
    end
  end

  assign data_rdStrobe      = r_strobe;
  assign word_count         = r_word_count;
  assign error_count        = r_err_count;
  assign first_err_data     = r_first_data;
  assign first_err_expected = r_first_exp;
  assign status             = {(r_state != S_IDLE), (r_state == S_HALT), r_err_seen, r_locked};

endmodule

// File: tb/tb_test_data_checker.sv
// Directed bench for test_data_checker: free-run lock, reset, error capture,
// counter wrap, strobe timing, error saturation, stop-on-error and clear.
module tb_test_data_checker;

  localparam int DW = 32;
  localparam int EW = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   control;
  logic [DW-1:0] data;
  logic          stb;
  logic [31:0]   wc;
  logic [EW-1:0] ec;
  logic [DW-1:0] fdata;
  logic [DW-1:0] fexp;
  logic [3:0]    status;

  int n_chk = 0;
  int n_err = 0;

  test_data_checker #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW), .RD_GAP(3)) dut (
    .axi_clk            (clk),
    .axi_resetn         (rstn),
    .control            (control),
    .data               (data),
    .data_rdStrobe      (stb),
    .word_count         (wc),
    .error_count        (ec),
    .first_err_data     (fdata),
    .first_err_expected (fexp),
    .status             (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word for one full cycle; returns on the following negedge.
  task automatic cyc(input logic [31:0] d);
    data = d;
    @(negedge clk);
  endtask

  logic [31:0] words [5];
  int          k, nstb, first, last;
  logic        prev;

  initial begin
    rstn = 1'b0; control = '0; data = '0;
    repeat (2) @(negedge clk);
    chk("rst_wc", wc, 0);
    chk("rst_ec", 32'(ec), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_stb", 32'(stb), 0);
    rstn = 1'b1;

    // Free-run lock and count
    control = 32'd1;
    @(negedge clk);
    chk("fr_sync_status", 32'(status), 32'h8);
    cyc(5);
    chk("fr_locked", 32'(status), 32'h9);
    chk("fr_wc1", wc, 1);
    for (int i = 6; i <= 9; i++) cyc(i);
    chk("fr_wc5", wc, 5);
    chk("fr_ec0", 32'(ec), 0);
    chk("fr_no_stb", 32'(stb), 0);

    // Asynchronous reset mid-run
    #2 rstn = 1'b0;
    #1;
    chk("arst_wc", wc, 0);
    chk("arst_status", 32'(status), 0);
    chk("arst_stb", 32'(stb), 0);
    control = '0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_idle_stb", 32'(stb), 0);
    chk("arst_idle_status", 32'(status), 0);

    // Error injection: 10,11,99,100
    control = 32'd3;
    @(negedge clk);
    control = 32'd1;
    cyc(10); cyc(11); cyc(99);
    chk("inj_ec", 32'(ec), 1);
    chk("inj_fdata", fdata, 99);
    chk("inj_fexp", fexp, 12);
    chk("inj_status", 32'(status), 32'hB);
    cyc(100);
    chk("inj_ec_after", 32'(ec), 1);
    chk("inj_wc", wc, 4);

    // Clear, then modulo wrap
    control = 32'd3;
    @(negedge clk);
    chk("clr_wc", wc, 0);
    chk("clr_ec", 32'(ec), 0);
    chk("clr_fdata", fdata, 0);
    control = 32'd1;
    cyc(32'hFFFF_FFFE); cyc(32'hFFFF_FFFF); cyc(32'h0); cyc(32'h1);
    chk("wrap_ec", 32'(ec), 0);
    chk("wrap_wc", wc, 4);

    // Strobe mode, source advances on each strobe
    control = 32'd7;
    @(negedge clk);
    control = 32'd5;
    data = 32'h20;
    prev = 1'b0; nstb = 0; first = -1; last = -1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (prev) data = data + 32'd1;
      prev = stb;
      if (stb) begin
        if (nstb == 0) first = i;
        else chk("stb_period", 32'(i - last), 4);
        last = i;
        nstb++;
      end
    end
    @(negedge clk);
    chk("stb_first", 32'(first), 0);
    chk("stb_count", 32'(nstb), 6);
    chk("stb_wc", wc, 32'(nstb));
    chk("stb_ec", 32'(ec), 0);

    // Error counter saturation (3-bit counter)
    control = 32'd3;
    @(negedge clk);
    control = 32'd1;
    cyc(0);
    for (int i = 0; i < 9; i++) cyc(0);
    chk("sat_ec", 32'(ec), 7);
    chk("sat_wc", wc, 10);
    chk("sat_fdata", fdata, 0);
    chk("sat_fexp", fexp, 1);

    // Stop on error in strobe mode, then clear
    words[0] = 32'd1; words[1] = 32'd2; words[2] = 32'd50;
    words[3] = 32'd51; words[4] = 32'd52;
    control = 32'd15;
    @(negedge clk);
    control = 32'd13;
    k = 0; data = words[0]; prev = 1'b0; nstb = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (prev && k < 4) begin
        k++;
        data = words[k];
      end
      prev = stb;
      if (stb) nstb++;
    end
    chk("halt_strobes", 32'(nstb), 3);
    chk("halt_wc", wc, 3);
    chk("halt_ec", 32'(ec), 1);
    chk("halt_status", 32'(status), 32'hF);
    chk("halt_fdata", fdata, 50);
    chk("halt_fexp", fexp, 3);
    control = 32'd15;
    @(negedge clk);
    chk("hclr_wc", wc, 0);
    chk("hclr_ec", 32'(ec), 0);
    chk("hclr_status", 32'(status), 32'h8);
    control = 32'd13;
    @(negedge clk);
    chk("hclr_relock_stb", 32'(stb), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
